// File: rtl/fetch_iqueue.sv
// Fetch unit with block-wide icache requests feeding an in-order instruction queue for decode.
// Head is valid one cycle after a hit; requests stall until the whole remaining block fits (no credit for same-cycle pops).
module fetch_iqueue #(
  parameter int ADDR_SIZE  = 32,
  parameter int ISA_SIZE   = 32,
  parameter int BLOCK_SIZE = 64,
  parameter int IQ_DEPTH   = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  output logic                          ic_req_o,
  output logic [ADDR_SIZE-1:0]          ic_pc_o,
  input  logic [BLOCK_SIZE-1:0]         ic_block_i,
  input  logic                          ic_hit_i,
  input  logic                          redirect_i,
  input  logic [ADDR_SIZE-1:0]          redirect_pc_i,
  output logic                          dec_valid_o,
  output logic [ISA_SIZE-1:0]           dec_inst_o,
  output logic [ADDR_SIZE-1:0]          dec_pc_o,
  input  logic                          dec_ready_i,
  output logic                          iq_full_o,
  output logic                          iq_empty_o,
  output logic [$clog2(IQ_DEPTH):0]     iq_count_o
);

  localparam int N        = BLOCK_SIZE / ISA_SIZE;
  localparam int OFF_BITS = $clog2(N * 4);
  localparam int SLOT_W   = OFF_BITS - 2;
  localparam int PTR_W    = $clog2(IQ_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic [1:0] {RUN, WAIT_SPACE, FLUSH} state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_SIZE-1:0] r_fpc;
  logic [ISA_SIZE-1:0]  r_inst_q [IQ_DEPTH];
  logic [ADDR_SIZE-1:0] r_pc_q   [IQ_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]     r_count;

  logic [ADDR_SIZE-1:0] w_blk_pc;
  logic [SLOT_W-1:0]    w_off;
  logic [CNT_W-1:0]     w_need, w_free;
  logic                 w_space, w_req, w_push, w_pop;

  assign w_blk_pc = r_fpc & ~ADDR_SIZE'(N * 4 - 1);
  assign w_off    = r_fpc[OFF_BITS-1:2];
  assign w_need   = CNT_W'(N) - CNT_W'(w_off);
  assign w_free   = CNT_W'(IQ_DEPTH) - r_count;
  assign w_space  = (w_free >= w_need);

  assign ic_req_o = w_req & rst_ni;
  assign ic_pc_o  = w_blk_pc;
  assign w_push   = ic_req_o & ic_hit_i & ~redirect_i;
  assign w_pop    = dec_valid_o & dec_ready_i & ~redirect_i;

  assign dec_valid_o = (r_count != '0);
  assign iq_empty_o  = (r_count == '0);
  assign iq_full_o   = (r_count == CNT_W'(IQ_DEPTH));
  assign iq_count_o  = r_count;
  assign dec_inst_o  = r_inst_q[r_rd_ptr];
  assign dec_pc_o    = r_pc_q[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      RUN: begin
        w_req = w_space;
        if (!w_space) w_state_nxt = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        w_req = w_space;
        if (w_space) w_state_nxt = RUN;
      end
      FLUSH:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
    if (redirect_i) w_state_nxt = FLUSH;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fpc    <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_fpc    <= redirect_pc_i & ~ADDR_SIZE'(3);
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fpc    <= w_blk_pc + ADDR_SIZE'(N * 4);
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_need);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (w_push ? w_need : '0) - CNT_W'(w_pop);
    end
  end

  // Slots below the entry offset are skipped; the rest pack contiguously from the write pointer.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      for (int j = 0; j < N; j++) begin
        if (SLOT_W'(j) >= w_off) begin
          r_inst_q[r_wr_ptr + PTR_W'(j) - PTR_W'(w_off)] <= ic_block_i[j*ISA_SIZE +: ISA_SIZE];
          r_pc_q[r_wr_ptr + PTR_W'(j) - PTR_W'(w_off)]   <= w_blk_pc + ADDR_SIZE'(4 * j);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_iqueue.sv
// Directed bench for fetch_iqueue: icache modelled as a pure function of the request address.
module tb_fetch_iqueue;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ic_req_o;
  logic [31:0] ic_pc_o;
  logic [63:0] ic_block_i;
  logic        ic_hit_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        dec_valid_o;
  logic [31:0] dec_inst_o;
  logic [31:0] dec_pc_o;
  logic        dec_ready_i;
  logic        iq_full_o, iq_empty_o;
  logic [2:0]  iq_count_o;
  logic        poison;
  int          errors = 0;
  int          checks = 0;

  fetch_iqueue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ic_req_o(ic_req_o), .ic_pc_o(ic_pc_o),
    .ic_block_i(ic_block_i), .ic_hit_i(ic_hit_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .dec_valid_o(dec_valid_o), .dec_inst_o(dec_inst_o),
    .dec_pc_o(dec_pc_o), .dec_ready_i(dec_ready_i), .iq_full_o(iq_full_o),
    .iq_empty_o(iq_empty_o), .iq_count_o(iq_count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0020_0093;
    else if (a == 32'h4) return 32'h0040_0113;
    else                 return 32'hC0DE_0000 ^ a;
  endfunction

  always_comb begin
    if (poison) ic_block_i = {2{32'hDEAD_BEEF}};
    else        ic_block_i = {inst_at(ic_pc_o + 32'd4), inst_at(ic_pc_o)};
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; ic_hit_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    dec_ready_i = 1'b0; poison = 1'b0;
    tick();
    rst_ni = 1'b1; #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; ic_hit_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    dec_ready_i = 1'b0; poison = 1'b0; #1;
    checks++; if (ic_req_o !== 1'b0) begin errors++; $display("FAIL reset_req_low: got %b want 0", ic_req_o); end
    tick();
    checks++; if (iq_count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", iq_count_o); end
    checks++; if (iq_empty_o !== 1'b1 || iq_full_o !== 1'b0 || dec_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: empty=%b full=%b valid=%b want 1 0 0", iq_empty_o, iq_full_o, dec_valid_o); end
    rst_ni = 1'b1; ic_hit_i = 1'b0; #1;
    checks++; if (ic_req_o !== 1'b1 || ic_pc_o !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: req=%b pc=%h want 1 00000000", ic_req_o, ic_pc_o); end
  endtask

  task automatic test_basic();
    do_reset();
    ic_hit_i = 1'b1; dec_ready_i = 1'b1; #1;
    tick();
    checks++; if (dec_valid_o !== 1'b1 || dec_inst_o !== 32'h0020_0093 || dec_pc_o !== 32'h0) begin
      errors++; $display("FAIL basic_head0: v=%b inst=%h pc=%h want 1 00200093 0", dec_valid_o, dec_inst_o, dec_pc_o); end
    checks++; if (iq_count_o !== 3'd2) begin errors++; $display("FAIL basic_count0: got %0d want 2", iq_count_o); end
    tick();
    checks++; if (dec_inst_o !== 32'h0040_0113 || dec_pc_o !== 32'h4) begin
      errors++; $display("FAIL basic_head1: inst=%h pc=%h want 00400113 4", dec_inst_o, dec_pc_o); end
    checks++; if (iq_count_o !== 3'd3) begin errors++; $display("FAIL basic_count1: got %0d want 3", iq_count_o); end
  endtask

  task automatic test_full();
    do_reset();
    ic_hit_i = 1'b1; dec_ready_i = 1'b0; #1;
    tick(); tick();
    checks++; if (iq_count_o !== 3'd4 || iq_full_o !== 1'b1 || ic_req_o !== 1'b0) begin
      errors++; $display("FAIL full_stall: count=%0d full=%b req=%b want 4 1 0", iq_count_o, iq_full_o, ic_req_o); end
    dec_ready_i = 1'b1; #1;
    checks++; if (ic_req_o !== 1'b0) begin errors++; $display("FAIL full_no_pop_credit: req=%b want 0", ic_req_o); end
    tick();
    checks++; if (iq_count_o !== 3'd3 || ic_req_o !== 1'b0 || dec_pc_o !== 32'h4) begin
      errors++; $display("FAIL full_pop1: count=%0d req=%b pc=%h want 3 0 4", iq_count_o, ic_req_o, dec_pc_o); end
    tick();
    checks++; if (iq_count_o !== 3'd2 || ic_req_o !== 1'b1 || ic_pc_o !== 32'h10) begin
      errors++; $display("FAIL full_resume: count=%0d req=%b pc=%h want 2 1 10", iq_count_o, ic_req_o, ic_pc_o); end
    dec_ready_i = 1'b0; #1;
    tick();
    checks++; if (iq_count_o !== 3'd4 || dec_pc_o !== 32'h8) begin
      errors++; $display("FAIL full_refill: count=%0d pc=%h want 4 8", iq_count_o, dec_pc_o); end
  endtask

  task automatic test_redirect();
    do_reset();
    ic_hit_i = 1'b1; #1;
    tick();
    dec_ready_i = 1'b1; #1;
    tick();
    ic_hit_i = 1'b0; dec_ready_i = 1'b0; #1;
    checks++; if (iq_count_o !== 3'd3) begin errors++; $display("FAIL redir_pre_count: got %0d want 3", iq_count_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h106; #1;
    tick();
    redirect_i = 1'b0; ic_hit_i = 1'b1; #1;
    checks++; if (iq_count_o !== 3'd0 || dec_valid_o !== 1'b0 || ic_req_o !== 1'b0) begin
      errors++; $display("FAIL redir_flush: count=%0d valid=%b req=%b want 0 0 0", iq_count_o, dec_valid_o, ic_req_o); end
    tick();
    checks++; if (ic_pc_o !== 32'h100 || ic_req_o !== 1'b1) begin
      errors++; $display("FAIL redir_req: pc=%h req=%b want 100 1", ic_pc_o, ic_req_o); end
    tick();
    ic_hit_i = 1'b0; #1;
    checks++; if (iq_count_o !== 3'd1 || dec_pc_o !== 32'h104 || dec_inst_o !== 32'hC0DE_0104) begin
      errors++; $display("FAIL redir_slot1: count=%0d pc=%h inst=%h want 1 104 c0de0104", iq_count_o, dec_pc_o, dec_inst_o); end
  endtask

  task automatic test_redirect_hit_pop();
    do_reset();
    ic_hit_i = 1'b1; #1;
    tick();
    poison = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200; dec_ready_i = 1'b1; #1;
    tick();
    poison = 1'b0; redirect_i = 1'b0; dec_ready_i = 1'b0; #1;
    checks++; if (iq_count_o !== 3'd0 || dec_valid_o !== 1'b0) begin
      errors++; $display("FAIL rhp_cleared: count=%0d valid=%b want 0 0", iq_count_o, dec_valid_o); end
    tick();
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL rhp_flush_empty: valid=%b want 0", dec_valid_o); end
    tick();
    checks++; if (dec_inst_o === 32'hDEAD_BEEF || dec_pc_o !== 32'h200 || dec_inst_o !== 32'hC0DE_0200 || iq_count_o !== 3'd2) begin
      errors++; $display("FAIL rhp_head: inst=%h pc=%h count=%0d want c0de0200 200 2", dec_inst_o, dec_pc_o, iq_count_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ic_hit_i = 1'b1; #1;
    tick();
    dec_ready_i = 1'b1; #1;
    tick();
    checks++; if (iq_count_o !== 3'd3) begin errors++; $display("FAIL rmid_pre_count: got %0d want 3", iq_count_o); end
    rst_ni = 1'b0; #1;
    checks++; if (ic_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req_in_reset: req=%b want 0", ic_req_o); end
    tick();
    rst_ni = 1'b1; ic_hit_i = 1'b0; dec_ready_i = 1'b0; #1;
    checks++; if (iq_count_o !== 3'd0 || dec_valid_o !== 1'b0 || ic_pc_o !== 32'h0 || ic_req_o !== 1'b1) begin
      errors++; $display("FAIL rmid_after: count=%0d valid=%b pc=%h req=%b want 0 0 0 1", iq_count_o, dec_valid_o, ic_pc_o, ic_req_o); end
    rst_ni = 1'b0; ic_hit_i = 1'b1; #1;
    checks++; if (ic_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req_gate: req=%b want 0", ic_req_o); end
    tick();
    rst_ni = 1'b1; ic_hit_i = 1'b0; #1;
    checks++; if (iq_count_o !== 3'd0) begin errors++; $display("FAIL rmid_hit_discard: count=%0d want 0", iq_count_o); end
  endtask

  task automatic test_random_stream();
    int          exp_idx = 0;
    int          blocks  = 0;
    logic [31:0] exp_pc;
    do_reset();
    for (int cyc = 0; cyc < 400 && exp_idx < 40; cyc++) begin
      dec_ready_i = 1'($urandom_range(0, 1));
      ic_hit_i    = (blocks < 20);
      #1;
      checks++; if (iq_count_o > 3'd4) begin errors++; $display("FAIL rand_count_bound: got %0d want <=4", iq_count_o); end
      if (dec_valid_o && dec_ready_i) begin
        exp_pc = 32'(exp_idx * 4);
        checks++;
        if (dec_pc_o !== exp_pc || dec_inst_o !== inst_at(exp_pc)) begin
          errors++; $display("FAIL rand_order: pc=%h inst=%h want %h %h", dec_pc_o, dec_inst_o, exp_pc, inst_at(exp_pc)); end
        exp_idx++;
      end
      if (ic_req_o && ic_hit_i) blocks++;
      tick();
    end
    checks++; if (exp_idx != 40) begin errors++; $display("FAIL rand_delivered: got %0d want 40", exp_idx); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_redirect();
    test_redirect_hit_pop();
    test_reset_mid();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_iqueue.md
FETCH_IQUEUE -- requirements
Module: fetch_iqueue

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_SIZE, 32, fetch address width.
- ISA_SIZE, 32, instruction width; 4 bytes per instruction.
- BLOCK_SIZE, 64, icache block width; N = BLOCK_SIZE/ISA_SIZE slots per block.
- IQ_DEPTH, 4, queue entries; power of two, >= N.
- RESET_PC, 0, first fetch address.

REQ-002 The block SHALL have these ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- ic_req_o  out  1  block request to icache.
- ic_pc_o  out  ADDR_SIZE  block-aligned request address.
- ic_block_i  in  BLOCK_SIZE  returned block; slot k = bits [k*ISA_SIZE +: ISA_SIZE], address ic_pc_o+4k.
- ic_hit_i  in  1  block valid for the current request (may be same cycle).
- redirect_i  in  1  branch/jump redirect.
- redirect_pc_i  in  ADDR_SIZE  redirect target.
- dec_valid_o  out  1  queue head valid.
- dec_inst_o  out  ISA_SIZE  head instruction.
- dec_pc_o  out  ADDR_SIZE  head address.
- dec_ready_i  in  1  decode accepts head.
- iq_full_o, iq_empty_o  out  1 each  queue status.
- iq_count_o  out  $clog2(IQ_DEPTH)+1  occupancy.

Function
REQ-003 The block SHALL hold a fetch PC register fpc; the low 2 bits SHALL always be zero (redirect_pc_i[1:0] ignored).
REQ-004 ic_pc_o SHALL equal fpc with the low log2(N*4) bits cleared; offset o = fpc slot index within the block.
REQ-005 FSM states SHALL be RUN, WAIT_SPACE and FLUSH.
REQ-006 In RUN, ic_req_o SHALL be 1 iff IQ_DEPTH - count >= N - o; otherwise ic_req_o SHALL be 0 and the next state SHALL be WAIT_SPACE.
REQ-007 WAIT_SPACE SHALL return to RUN in the cycle that the space condition of REQ-006 holds, asserting ic_req_o in that same cycle.
REQ-008 The space check SHALL use the count at the start of the cycle and SHALL NOT credit a same-cycle pop.
REQ-009 On a clock edge with ic_req_o=1, ic_hit_i=1 and redirect_i=0, the block SHALL write slots o..N-1 in ascending order, with their PCs, into the queue and set fpc to ic_pc_o + N*4.
REQ-010 ic_pc_o SHALL remain stable while ic_req_o=1 and ic_hit_i=0.
REQ-011 A pop SHALL occur on each edge with dec_valid_o=1 and dec_ready_i=1; dec_valid_o SHALL equal !iq_empty_o.
REQ-012 dec_inst_o and dec_pc_o SHALL be driven from the queue head register; the latency from the hit edge to dec_valid_o=1 SHALL be one cycle.
REQ-013 With a same-cycle push of m and a pop, count SHALL become count+m-1; the read and write pointers SHALL wrap modulo IQ_DEPTH, and FIFO order SHALL be preserved.
REQ-014 redirect_i=1 SHALL have priority over all other events:
- count, read pointer and write pointer SHALL be cleared;
- any same-cycle hit data SHALL be discarded;
- any same-cycle pop SHALL be void;
- fpc SHALL be loaded with redirect_pc_i;
- the next state SHALL be FLUSH.
REQ-015 FLUSH SHALL last exactly one cycle with ic_req_o=0, then go to RUN; a redirect during FLUSH SHALL reload fpc and remain in FLUSH.
REQ-016 iq_full_o SHALL be (count==IQ_DEPTH); iq_empty_o SHALL be (count==0); writes SHALL never exceed capacity.

Reset
REQ-017 While rst_ni=0 at an edge, the next state SHALL be:
- state=RUN, fpc=RESET_PC;
- count=0 and both pointers=0;
- dec_valid_o=0, iq_empty_o=1, iq_full_o=0, iq_count_o=0.
REQ-018 ic_req_o SHALL be 0 in any cycle where rst_ni=0; reset mid-operation SHALL discard queue contents and any same-cycle hit.

Verification
REQ-019 Reset, then ic_hit_i=1 every cycle, block@0={0x00400113,0x00200093}, dec_ready_i=1 -> dec_valid_o=1 with 0x00200093/pc 0 one cycle after the hit edge, then 0x00400113/pc 4.
REQ-020 IQ_DEPTH=4, dec_ready_i=0, hits always -> after two hit edges iq_count_o=4, iq_full_o=1, ic_req_o=0 (WAIT_SPACE); after ready=1 for 2 pops, ic_req_o=1 again at count 2.
REQ-021 With 3 entries queued, redirect_i=1, redirect_pc_i=0x106 -> next cycle count 0, dec_valid_o=0, ic_req_o=0 (FLUSH); following cycle ic_pc_o=0x100; the hit pushes only slot 1, and the head has pc 0x104.
REQ-022 Redirect coinciding with a hit and a pop -> count 0 afterwards and no hit data ever appears on dec_inst_o.
REQ-023 rst_ni=0 for one edge with count=3 mid-stream -> count 0, fpc=RESET_PC, ic_req_o=0 during reset, request to RESET_PC in the next cycle.
REQ-024 Random dec_ready_i over 20 consecutive blocks -> all 40 instructions delivered in order with correct PCs across pointer wrap; iq_count_o never exceeds 4.
